// File: rtl/cdc_4phase_src_arb.sv
// Source half of a multi-channel 4-phase CDC link: round-robin arbitrates
// valid/ready channels onto one tagged req/ack/data handshake.
module cdc_4phase_src_arb #(
   parameter int unsigned     WIDTH          = 32,
   parameter int unsigned     NUM_CHAN       = 4,
   parameter int unsigned     SYNC_STAGES    = 2,
   parameter bit              DECOUPLED      = 1'b1,
   parameter bit              SEND_RESET_MSG = 1'b0,
   parameter logic [WIDTH-1:0] RESET_MSG     = '0,
   parameter int unsigned     CNT_WIDTH      = 16,
   localparam int unsigned    CHAN_W         = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_CHAN-1:0]       valid_i,
   input  logic [NUM_CHAN*WIDTH-1:0] data_i,
   output logic [NUM_CHAN-1:0]       ready_o,
   output logic                      async_req_o,
   input  logic                      async_ack_i,
   output logic [WIDTH-1:0]          async_data_o,
   output logic [CHAN_W-1:0]         async_chan_o,
   output logic                      busy_o,
   output logic [CNT_WIDTH-1:0]      txn_cnt_o
);

   typedef enum logic [1:0] {
      IDLE              = 2'd0,
      WAIT_ACK_ASSERT   = 2'd1,
      WAIT_ACK_DEASSERT = 2'd2
   } state_e;

   state_e                r_state;
   state_e                w_stateNext;
   logic                  r_req;
   logic                  w_reqNext;
   logic [WIDTH-1:0]      r_data;
   logic [CHAN_W-1:0]     r_chan;
   logic [CHAN_W-1:0]     r_rrPtr;
   logic [CHAN_W-1:0]     w_rrPtrNext;
   logic [CHAN_W-1:0]     w_grant;
   logic [CHAN_W-1:0]     w_idx;
   logic                  w_anyValid;
   logic                  w_load;
   logic                  w_countInc;
   logic                  w_clrRstMsg;
   logic                  r_rstMsg;
   logic [SYNC_STAGES-1:0] r_ackSync;
   logic                  w_ackSynced;
   logic [CNT_WIDTH-1:0]  r_txnCnt;
   logic [WIDTH-1:0]      w_chanData [NUM_CHAN];

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_unpack
      assign w_chanData[c] = data_i[c*WIDTH +: WIDTH];
   end

   // Only the acknowledge crosses domains; everything else is local to clk_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ackSync <= '0;
      end else begin
         r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], async_ack_i};
      end
   end

   assign w_ackSynced = r_ackSync[SYNC_STAGES-1];

   // Round-robin search starting at the channel after the last one served.
   always_comb begin
      w_grant    = '0;
      w_anyValid = 1'b0;
      w_idx      = '0;
      for (int unsigned i = 0; i < NUM_CHAN; i++) begin
         w_idx = CHAN_W'((32'(r_rrPtr) + i) % NUM_CHAN);
         if (!w_anyValid && valid_i[w_idx]) begin
            w_grant    = w_idx;
            w_anyValid = 1'b1;
         end
      end
      w_rrPtrNext = (32'(w_grant) == NUM_CHAN - 1) ? '0 : w_grant + 1'b1;
   end

   always_comb begin
      w_stateNext = r_state;
      w_reqNext   = r_req;
      w_load      = 1'b0;
      w_countInc  = 1'b0;
      w_clrRstMsg = 1'b0;
      ready_o     = '0;
      case (r_state)
         IDLE: begin
            w_reqNext = 1'b0;
            if (w_anyValid) begin
               w_load      = 1'b1;
               w_reqNext   = 1'b1;
               w_stateNext = WAIT_ACK_ASSERT;
               if (DECOUPLED) ready_o[w_grant] = 1'b1;
            end
         end
         WAIT_ACK_ASSERT: begin
            w_reqNext = 1'b1;
            if (w_ackSynced) begin
               w_reqNext   = 1'b0;
               w_stateNext = WAIT_ACK_DEASSERT;
            end
         end
         WAIT_ACK_DEASSERT: begin
            w_reqNext = 1'b0;
            if (!w_ackSynced) begin
               w_stateNext = IDLE;
               w_countInc  = !r_rstMsg;
               w_clrRstMsg = 1'b1;
               if (!DECOUPLED && !r_rstMsg) ready_o[r_chan] = 1'b1;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_reqNext   = 1'b0;
         end
      endcase
   end

   // The reset message, if enabled, starts life already mid-handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= SEND_RESET_MSG ? WAIT_ACK_ASSERT : IDLE;
         r_req    <= SEND_RESET_MSG;
         r_data   <= SEND_RESET_MSG ? RESET_MSG : '0;
         r_chan   <= '0;
         r_rstMsg <= SEND_RESET_MSG;
         r_rrPtr  <= '0;
         r_txnCnt <= '0;
      end else begin
         r_state <= w_stateNext;
         r_req   <= w_reqNext;
         if (w_load) begin
            r_data  <= w_chanData[w_grant];
            r_chan  <= w_grant;
            r_rrPtr <= w_rrPtrNext;
         end
         if (w_countInc) r_txnCnt <= r_txnCnt + 1'b1;
         if (w_clrRstMsg) r_rstMsg <= 1'b0;
      end
   end

   assign async_req_o  = r_req;
   assign async_data_o = r_data;
   assign async_chan_o = r_chan;
   assign busy_o       = (r_state != IDLE);
   assign txn_cnt_o    = r_txnCnt;

endmodule

// File: tb/tb_cdc_4phase_src_arb.sv
// Bench for cdc_4phase_src_arb: a decoupled instance (A) and a coupled,
// reset-message, 2-bit-counter instance (B), each with a 3-cycle ack echo.
module tb_cdc_4phase_src_arb;

   typedef struct {
      logic [1:0]  chan;
      logic [31:0] data;
   } item_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   item_t sbA[$];
   item_t sbB[$];

   logic         rstA = 1'b1;
   logic [3:0]   validA = '0;
   logic [127:0] dataA = '0;
   logic [3:0]   readyA;
   logic         reqA;
   logic         ackA;
   logic [31:0]  outDataA;
   logic [1:0]   chanA;
   logic         busyA;
   logic [15:0]  cntA;
   logic [2:0]   echoA = '0;

   logic         rstB = 1'b1;
   logic [3:0]   validB = '0;
   logic [127:0] dataB = '0;
   logic [3:0]   readyB;
   logic         reqB;
   logic         ackB;
   logic [31:0]  outDataB;
   logic [1:0]   chanB;
   logic         busyB;
   logic [1:0]   cntB;
   logic [2:0]   echoB = '0;

   // Destination stand-in: acknowledge is the request delayed by three cycles.
   always @(posedge clk) echoA <= {echoA[1:0], reqA};
   always @(posedge clk) echoB <= {echoB[1:0], reqB};
   assign ackA = echoA[2];
   assign ackB = echoB[2];

   cdc_4phase_src_arb dutA (
      .clk_i(clk), .rst_ni(rstA), .valid_i(validA), .data_i(dataA), .ready_o(readyA),
      .async_req_o(reqA), .async_ack_i(ackA), .async_data_o(outDataA),
      .async_chan_o(chanA), .busy_o(busyA), .txn_cnt_o(cntA)
   );

   cdc_4phase_src_arb #(
      .DECOUPLED(1'b0), .SEND_RESET_MSG(1'b1), .RESET_MSG(32'hDEAD_BEEF), .CNT_WIDTH(2)
   ) dutB (
      .clk_i(clk), .rst_ni(rstB), .valid_i(validB), .data_i(dataB), .ready_o(readyB),
      .async_req_o(reqB), .async_ack_i(ackB), .async_data_o(outDataB),
      .async_chan_o(chanB), .busy_o(busyB), .txn_cnt_o(cntB)
   );

   task automatic waitReqA(input logic level, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (reqA === level) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic waitIdleA(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busyA === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Coupled transfer on B: hold valid until ready, then drop it after that edge.
   task automatic xferB(input int ch, input logic [31:0] d, output bit ok,
                        output int readyCycles, output logic [3:0] readyMask,
                        output bit readyInGrant, output bit stable, output logic gotReq,
                        output logic [1:0] gotChan, output logic [31:0] gotData);
      ok = 1'b0;
      readyCycles = 0;
      readyMask = '0;
      stable = 1'b1;
      dataB[ch*32 +: 32] = d;
      @(posedge clk);
      #1 validB = 4'(1 << ch);
      @(negedge clk);
      readyInGrant = (readyB !== 4'b0000);
      @(negedge clk);
      gotReq  = reqB;
      gotChan = chanB;
      gotData = outDataB;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (outDataB !== gotData || chanB !== gotChan) stable = 1'b0;
         if (readyB !== 4'b0000) begin
            readyCycles++;
            readyMask = readyB;
            if (reqB !== 1'b0) stable = 1'b0;
            @(posedge clk);
            #1 validB = '0;
         end
         if (busyB === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      validB = '0;
   endtask

   task automatic test_reset();
      checks++;
      if (reqA !== 1'b0 || busyA !== 1'b0 || readyA !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL reset_ctrl: req=%b busy=%b ready=%b, expected 0 0 0000", reqA, busyA, readyA);
      end
      checks++;
      if (cntA !== 16'd0 || outDataA !== 32'd0 || chanA !== 2'd0) begin
         fails++;
         $display("[TB] FAIL reset_regs: cnt=%0d data=%h chan=%0d, expected 0 0 0", cntA, outDataA, chanA);
      end
      @(negedge clk);
      rstA = 1'b1;
   endtask

   task automatic test_round_robin();
      item_t it;
      item_t exp;
      bit ok;
      for (int c = 0; c < 4; c++) dataA[c*32 +: 32] = 32'hCAFE_0000 + 32'(c);
      @(posedge clk);
      #1 validA = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         it.chan = 2'(k % 4);
         it.data = 32'hCAFE_0000 + 32'(k % 4);
         sbA.push_back(it);
         waitReqA(1'b0, 40, ok);
         if (ok) waitReqA(1'b1, 40, ok);
         if (k == 4) validA = '0;
         exp = sbA.pop_front();
         checks++;
         if (!ok) begin
            fails++;
            $display("[TB] FAIL rr_req_timeout: item %0d, req=%b expected rise", k, reqA);
         end
         checks++;
         if (chanA !== exp.chan || outDataA !== exp.data) begin
            fails++;
            $display("[TB] FAIL rr_item: item %0d got chan %0d data %h, expected chan %0d data %h",
                     k, chanA, outDataA, exp.chan, exp.data);
         end
      end
      waitIdleA(40, ok);
      checks++;
      if (!ok || cntA !== 16'd5) begin
         fails++;
         $display("[TB] FAIL rr_count: idle=%b cnt=%0d, expected idle 1 cnt 5", ok, cntA);
      end
   endtask

   task automatic test_single_channel();
      item_t it;
      item_t exp;
      bit ok;
      dataA[2*32 +: 32] = 32'hCAFE_0002;
      it.chan = 2'd2;
      it.data = 32'hCAFE_0002;
      @(posedge clk);
      #1 validA = 4'b0100;
      sbA.push_back(it);
      @(negedge clk);
      checks++;
      if (readyA !== 4'b0100 || reqA !== 1'b0) begin
         fails++;
         $display("[TB] FAIL single_grant_cycle: ready=%b req=%b, expected 0100 0", readyA, reqA);
      end
      @(negedge clk);
      validA = '0;
      exp = sbA.pop_front();
      checks++;
      if (reqA !== 1'b1 || readyA !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL single_req_rise: req=%b ready=%b, expected 1 0000", reqA, readyA);
      end
      checks++;
      if (chanA !== exp.chan || outDataA !== exp.data) begin
         fails++;
         $display("[TB] FAIL single_item: chan %0d data %h, expected chan %0d data %h",
                  chanA, outDataA, exp.chan, exp.data);
      end
      waitIdleA(40, ok);
      checks++;
      if (!ok || cntA !== 16'd6) begin
         fails++;
         $display("[TB] FAIL single_count: idle=%b cnt=%0d, expected idle 1 cnt 6", ok, cntA);
      end
   endtask

   task automatic test_reset_midflight();
      item_t it;
      item_t exp;
      bit ok;
      dataA[3*32 +: 32] = 32'h1234_0003;
      @(posedge clk);
      #1 validA = 4'b1000;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (reqA !== 1'b1 || busyA !== 1'b1) begin
         fails++;
         $display("[TB] FAIL midflight_pre: req=%b busy=%b, expected 1 1", reqA, busyA);
      end
      validA = '0;
      rstA = 1'b0;
      #1;
      checks++;
      if (reqA !== 1'b0 || busyA !== 1'b0 || readyA !== 4'b0000 || cntA !== 16'd0) begin
         fails++;
         $display("[TB] FAIL midflight_reset: req=%b busy=%b ready=%b cnt=%0d, expected 0 0 0000 0",
                  reqA, busyA, readyA, cntA);
      end
      @(negedge clk);
      rstA = 1'b1;
      repeat (12) @(negedge clk);
      dataA[1*32 +: 32] = 32'h5555_0001;
      it.chan = 2'd1;
      it.data = 32'h5555_0001;
      sbA.push_back(it);
      @(posedge clk);
      #1 validA = 4'b0010;
      waitReqA(1'b1, 20, ok);
      validA = '0;
      exp = sbA.pop_front();
      checks++;
      if (!ok || chanA !== exp.chan || outDataA !== exp.data) begin
         fails++;
         $display("[TB] FAIL midflight_next: req_ok=%b chan %0d data %h, expected chan %0d data %h",
                  ok, chanA, outDataA, exp.chan, exp.data);
      end
      waitIdleA(40, ok);
      checks++;
      if (!ok || cntA !== 16'd1) begin
         fails++;
         $display("[TB] FAIL midflight_count: idle=%b cnt=%0d, expected idle 1 cnt 1", ok, cntA);
      end
   endtask

   task automatic test_reset_msg();
      bit ok;
      bit sawReady;
      checks++;
      if (reqB !== 1'b1 || outDataB !== 32'hDEAD_BEEF || chanB !== 2'd0) begin
         fails++;
         $display("[TB] FAIL rstmsg_during: req=%b data=%h chan=%0d, expected 1 deadbeef 0",
                  reqB, outDataB, chanB);
      end
      checks++;
      if (readyB !== 4'b0000 || cntB !== 2'd0 || busyB !== 1'b1) begin
         fails++;
         $display("[TB] FAIL rstmsg_ctrl: ready=%b cnt=%0d busy=%b, expected 0000 0 1", readyB, cntB, busyB);
      end
      @(negedge clk);
      rstB = 1'b1;
      ok = 1'b0;
      sawReady = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (readyB !== 4'b0000) sawReady = 1'b1;
         if (busyB === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || sawReady !== 1'b0) begin
         fails++;
         $display("[TB] FAIL rstmsg_done: idle=%b ready_pulse=%b, expected 1 0", ok, sawReady);
      end
      checks++;
      if (cntB !== 2'd0 || reqB !== 1'b0 || outDataB !== 32'hDEAD_BEEF) begin
         fails++;
         $display("[TB] FAIL rstmsg_after: cnt=%0d req=%b data=%h, expected 0 0 deadbeef", cntB, reqB, outDataB);
      end
   endtask

   task automatic test_coupled();
      item_t it;
      item_t exp;
      bit ok;
      int readyCycles;
      logic [3:0] readyMask;
      bit readyInGrant;
      bit stable;
      logic gotReq;
      logic [1:0] gotChan;
      logic [31:0] gotData;
      it.chan = 2'd1;
      it.data = 32'hCAFE_0101;
      sbB.push_back(it);
      xferB(1, 32'hCAFE_0101, ok, readyCycles, readyMask, readyInGrant, stable, gotReq, gotChan, gotData);
      exp = sbB.pop_front();
      checks++;
      if (gotReq !== 1'b1 || gotChan !== exp.chan || gotData !== exp.data) begin
         fails++;
         $display("[TB] FAIL coupled_item: req=%b chan %0d data %h, expected 1 chan %0d data %h",
                  gotReq, gotChan, gotData, exp.chan, exp.data);
      end
      checks++;
      if (!ok || readyInGrant || readyCycles !== 1 || readyMask !== 4'b0010) begin
         fails++;
         $display("[TB] FAIL coupled_ready: done=%b grant_ready=%b pulses=%0d mask=%b, expected 1 0 1 0010",
                  ok, readyInGrant, readyCycles, readyMask);
      end
      checks++;
      if (!stable || cntB !== 2'd1) begin
         fails++;
         $display("[TB] FAIL coupled_stable: stable=%b cnt=%0d, expected 1 1", stable, cntB);
      end
   endtask

   task automatic test_counter_wrap();
      item_t it;
      item_t exp;
      bit ok;
      int readyCycles;
      logic [3:0] readyMask;
      bit readyInGrant;
      bit stable;
      logic gotReq;
      logic [1:0] gotChan;
      logic [31:0] gotData;
      logic [1:0] expCnt;
      for (int k = 0; k < 4; k++) begin
         it.chan = 2'(k);
         it.data = 32'hB000_0000 + 32'(k);
         sbB.push_back(it);
         xferB(k, it.data, ok, readyCycles, readyMask, readyInGrant, stable, gotReq, gotChan, gotData);
         exp = sbB.pop_front();
         expCnt = 2'((2 + k) % 4);
         checks++;
         if (!ok || gotChan !== exp.chan || gotData !== exp.data || readyCycles !== 1) begin
            fails++;
            $display("[TB] FAIL wrap_item: k=%0d done=%b chan %0d data %h pulses %0d, expected chan %0d data %h pulses 1",
                     k, ok, gotChan, gotData, readyCycles, exp.chan, exp.data);
         end
         checks++;
         if (cntB !== expCnt) begin
            fails++;
            $display("[TB] FAIL wrap_count: k=%0d cnt=%0d, expected %0d", k, cntB, expCnt);
         end
      end
   endtask

   initial begin
      #1;
      rstA = 1'b0;
      rstB = 1'b0;
      #1;
      test_reset();
      test_round_robin();
      test_single_channel();
      test_reset_midflight();
      test_reset_msg();
      test_coupled();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Global watchdog so a stuck handshake can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
